motor_controller_multi: RTL and testbench

//  NUM_CH independent H-bridge drivers sharing one PWM timebase.
//  - Per channel: coast / forward / reverse / brake, with per-channel duty and enforced dead time on every mode change.
//  - Duty updates are glitch-free: each new duty is latched only at the PWM period wrap.
//  - Sits between the control-register block and the H-bridge gate pins.

---
 rtl/motor_controller_multi.sv | 178 +++++++++++++++++
 tb/tb_motor_controller_multi.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_controller_multi.sv
// NUM_CH H-bridge drivers on one shared PWM timebase, with per-channel dead time and wrap-latched duty.
// Optional MOTOR_RAMP_EN: duty shadow slews by +/-1 per PWM wrap and restarts from 0 on every DEAD/OFF.
module motor_controller_multi #(
  parameter int NUM_CH      = 4,
  parameter int PERIOD_W    = 10,
  parameter int DUTY_W      = 5,
  parameter int DEAD_CYCLES = 500,
  parameter int DEAD_W      = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        on,
  input  logic [NUM_CH-1:0]        dir,
  input  logic [NUM_CH-1:0]        brake,
  input  logic [NUM_CH*DUTY_W-1:0] duty_cycle,
  output logic [NUM_CH*4-1:0]      out,
  output logic [NUM_CH-1:0]        dead_active,
  output logic                     pwm_wrap
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_DEAD  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [1:0] MD_COAST = 2'd0;
  localparam logic [1:0] MD_FWD   = 2'd1;
  localparam logic [1:0] MD_REV   = 2'd2;
  localparam logic [1:0] MD_BRAKE = 2'd3;

  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  logic [PERIOD_W-1:0] pwm_cnt_q;
  logic [PERIOD_W-1:0] pwm_cnt_d;
  logic                pwm_wrap_q;
  logic                wrap_edge_s;

  assign pwm_cnt_d   = pwm_cnt_q + PERIOD_W'(1);
  assign wrap_edge_s = &pwm_cnt_q;
  assign pwm_wrap    = pwm_wrap_q;

  // Shared free-running timebase and its registered wrap pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q  <= {PERIOD_W{1'b0}};
      pwm_wrap_q <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_wrap_q <= wrap_edge_s;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_s;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [DUTY_W-1:0] duty_sh_q, duty_sh_d;
    logic [DUTY_W-1:0] duty_tgt_s;
    logic [3:0]        out_q, out_d, pattern_s;
    logic              dead_active_q;
    logic              pwm_on_s;

    assign duty_tgt_s = duty_cycle[g*DUTY_W +: DUTY_W];

    // Requested mode; brake overrides on and dir.
    always_comb begin
      if (brake[g]) begin
        mode_s = MD_BRAKE;
      end else if (on[g]) begin
        mode_s = dir[g] ? MD_FWD : MD_REV;
      end else begin
        mode_s = MD_COAST;
      end
    end

    // OFF/DEAD/DRIVE sequencing; any change of non-coast mode restarts the dead count.
    always_comb begin
      state_d    = state_q;
      dead_cnt_d = dead_cnt_q;
      case (state_q)
        ST_OFF: begin
          if (mode_s != MD_COAST) begin
            state_d    = ST_DEAD;
            dead_cnt_d = {DEAD_W{1'b0}};
          end else begin
            state_d    = ST_OFF;
          end
        end
        ST_DEAD: begin
          if (mode_s == MD_COAST) begin
            state_d    = ST_OFF;
            dead_cnt_d = {DEAD_W{1'b0}};
          end else if (mode_s != mode_q) begin
            dead_cnt_d = {DEAD_W{1'b0}};
          end else if (dead_cnt_q == DEAD_LAST) begin
            state_d    = ST_DRIVE;
            dead_cnt_d = {DEAD_W{1'b0}};
          end else begin
            dead_cnt_d = dead_cnt_q + DEAD_W'(1);
          end
        end
        ST_DRIVE: begin
          if (mode_s == MD_COAST) begin
            state_d = ST_OFF;
          end else if (mode_s != mode_q) begin
            state_d    = ST_DEAD;
            dead_cnt_d = {DEAD_W{1'b0}};
          end else begin
            state_d = ST_DRIVE;
          end
        end
        default: begin
          state_d    = ST_OFF;
          dead_cnt_d = {DEAD_W{1'b0}};
        end
      endcase
    end

    // Duty shadow only changes at the period wrap, so a running period never glitches.
    always_comb begin
`ifdef MOTOR_RAMP_EN
      if (state_d != ST_DRIVE) begin
        duty_sh_d = {DUTY_W{1'b0}};
      end else if (wrap_edge_s && (duty_sh_q < duty_tgt_s)) begin
        duty_sh_d = duty_sh_q + DUTY_W'(1);
      end else if (wrap_edge_s && (duty_sh_q > duty_tgt_s)) begin
        duty_sh_d = duty_sh_q - DUTY_W'(1);
      end else begin
        duty_sh_d = duty_sh_q;
      end
`else
      if (wrap_edge_s) begin
        duty_sh_d = duty_tgt_s;
      end else begin
        duty_sh_d = duty_sh_q;
      end
`endif
    end

    // Gate pattern for the next cycle, compared against the counter value that cycle will hold.
    always_comb begin
      case (mode_s)
        MD_FWD:   pattern_s = 4'b1001;
        MD_REV:   pattern_s = 4'b0110;
        MD_BRAKE: pattern_s = 4'b0101;
        default:  pattern_s = 4'b0000;
      endcase
      pwm_on_s = (pwm_cnt_d < PERIOD_W'(duty_sh_d));
      if ((state_d == ST_DRIVE) && ((mode_s == MD_BRAKE) || pwm_on_s)) begin
        out_d = pattern_s;
      end else begin
        out_d = 4'b0000;
      end
    end

    // Channel state and registered gate outputs.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q       <= ST_OFF;
        mode_q        <= MD_COAST;
        dead_cnt_q    <= {DEAD_W{1'b0}};
        duty_sh_q     <= {DUTY_W{1'b0}};
        out_q         <= 4'b0000;
        dead_active_q <= 1'b0;
      end else begin
        state_q       <= state_d;
        mode_q        <= mode_s;
        dead_cnt_q    <= dead_cnt_d;
        duty_sh_q     <= duty_sh_d;
        out_q         <= out_d;
        dead_active_q <= (state_d == ST_DEAD);
      end
    end

    assign out[g*4 +: 4] = out_q;
    assign dead_active[g] = dead_active_q;
  end

endmodule

// File: tb/tb_motor_controller_multi.sv
// Randomised and directed bench for motor_controller_multi (NUM_CH=2, PERIOD_W=4, DUTY_W=4, DEAD_CYCLES=8).
module tb_motor_controller_multi;

  localparam int NCH  = 2;
  localparam int DEAD = 8;
  localparam int PER  = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] on, dir, brake;
  logic [7:0] duty_cycle;
  logic [7:0] out;
  logic [1:0] dead_active;
  logic       pwm_wrap;

  int total = 0;
  int bad   = 0;

  motor_controller_multi #(
    .NUM_CH(2), .PERIOD_W(4), .DUTY_W(4), .DEAD_CYCLES(8), .DEAD_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .on(on), .dir(dir), .brake(brake),
    .duty_cycle(duty_cycle), .out(out), .dead_active(dead_active), .pwm_wrap(pwm_wrap)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset, run length of the current steady mode, wrap-latched duty.
  int         n;
  int         run   [NCH];
  int         mprev [NCH];
  logic [3:0] sh    [NCH];
  logic [3:0] exp_out  [NCH];
  logic       exp_dead [NCH];
  logic       exp_wrap;
  logic       m_load;
  int         m_mode;
  logic [3:0] m_cnt;
  logic [10:0] exp_vec;
  logic [10:0] got_vec;

  function automatic int mode_of(int ch);
    if (brake[ch]) return 3;
    if (on[ch]) return dir[ch] ? 1 : 2;
    return 0;
  endfunction

  function automatic logic [3:0] pat_of(int m);
    case (m)
      1:       return 4'b1001;
      2:       return 4'b0110;
      3:       return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n = 0;
      exp_wrap = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        run[ch] = 0; mprev[ch] = 0; sh[ch] = 4'd0; exp_out[ch] = 4'd0; exp_dead[ch] = 1'b0;
      end
    end else begin
      m_load = ((n % PER) == PER - 1);
      n = n + 1;
      m_cnt = 4'(n % PER);
      exp_wrap = (m_cnt == 4'd0);
      for (int ch = 0; ch < NCH; ch++) begin
        m_mode = mode_of(ch);
        if (m_mode == 0) run[ch] = 0;
        else if (m_mode == mprev[ch]) run[ch] = (run[ch] <= DEAD) ? run[ch] + 1 : run[ch];
        else run[ch] = 1;
        mprev[ch] = m_mode;
        if (m_load) sh[ch] = duty_cycle[ch*4 +: 4];
        exp_dead[ch] = (m_mode != 0) && (run[ch] <= DEAD);
        exp_out[ch] = ((m_mode != 0) && (run[ch] > DEAD) && ((m_mode == 3) || (m_cnt < sh[ch])))
                      ? pat_of(m_mode) : 4'b0000;
      end
    end
  end

  assign exp_vec = {exp_out[1], exp_out[0], exp_dead[1], exp_dead[0], exp_wrap};
  assign got_vec = {out, dead_active, pwm_wrap};

  task automatic test_reset();
    reset_n = 1'b0; on = 2'b11; dir = 2'b11; brake = 2'b00; duty_cycle = 8'h88;
    repeat (3) @(negedge clk);
    total++;
    if (out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h want=00", out); end
    total++;
    if (dead_active !== 2'b00) begin bad++; $display("FAIL reset_dead got=%b want=00", dead_active); end
    total++;
    if (pwm_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", pwm_wrap); end
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total++;
      if (c < DEAD && dead_active !== 2'b11) begin
        bad++; $display("FAIL reset_dead_window c=%0d got=%b want=11", c, dead_active);
      end else if (got_vec !== exp_vec) begin
        bad++; $display("FAIL reset_release c=%0d got=%h want=%h", c, got_vec, exp_vec);
      end
    end
  endtask

  task automatic test_forward();
    int ons;
    int waited;
    on = 2'b00; dir = 2'b01; brake = 2'b00; duty_cycle = 8'h04;
    repeat (2) @(negedge clk);
    on = 2'b01;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL fwd_model c=%0d got=%h want=%h", c, got_vec, exp_vec); end
    end
    waited = 0;
    while (pwm_wrap !== 1'b1 && waited < 32) begin @(negedge clk); waited++; end
    ons = 0;
    for (int c = 0; c < PER; c++) begin
      if (out[3:0] == 4'b1001) ons++;
      if (c < PER - 1) @(negedge clk);
    end
    total++;
    if (ons != 4) begin bad++; $display("FAIL fwd_ontime got=%0d want=4", ons); end
  endtask

  task automatic test_dir_toggle();
    dir[0] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      total++;
      if (c < DEAD && out[3:0] !== 4'b0000) begin
        bad++; $display("FAIL toggle_dead c=%0d got=%b want=0000", c, out[3:0]);
      end else if (got_vec !== exp_vec) begin
        bad++; $display("FAIL toggle_model c=%0d got=%h want=%h", c, got_vec, exp_vec);
      end
    end
    dir[0] = 1'b1;
    repeat (6) @(negedge clk);
    dir[0] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      total++;
      if (c < DEAD && dead_active[0] !== 1'b1) begin
        bad++; $display("FAIL toggle_restart c=%0d got=%b want=1", c, dead_active[0]);
      end else if (got_vec !== exp_vec) begin
        bad++; $display("FAIL toggle_restart_model c=%0d got=%h want=%h", c, got_vec, exp_vec);
      end
    end
  endtask

  task automatic test_duty_change();
    int ons;
    int waited;
    on = 2'b11; dir = 2'b11; duty_cycle = 8'h44;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL duty_pre c=%0d got=%h want=%h", c, got_vec, exp_vec); end
    end
    while (pwm_wrap !== 1'b1) @(negedge clk);
    repeat (6) @(negedge clk);
    duty_cycle = 8'hC4;
    waited = 0;
    while (pwm_wrap !== 1'b1 && waited < 32) begin
      @(negedge clk); waited++;
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL duty_hold w=%0d got=%h want=%h", waited, got_vec, exp_vec); end
    end
    ons = 0;
    for (int c = 0; c < PER; c++) begin
      if (out[7:4] == 4'b1001) ons++;
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL duty_new c=%0d got=%h want=%h", c, got_vec, exp_vec); end
      if (c < PER - 1) @(negedge clk);
    end
    total++;
    if (ons != 12) begin bad++; $display("FAIL duty_ontime got=%0d want=12", ons); end
  endtask

  task automatic test_brake();
    on = 2'b00; brake = 2'b00;
    repeat (2) @(negedge clk);
    brake[0] = 1'b1; duty_cycle = 8'h40;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL brake_model c=%0d got=%h want=%h", c, got_vec, exp_vec); end
    end
    total++;
    if (out[3:0] !== 4'b0101) begin bad++; $display("FAIL brake_hold got=%b want=0101", out[3:0]); end
    brake[0] = 1'b0; on[0] = 1'b0;
    @(negedge clk);
    total++;
    if (out[3:0] !== 4'b0000) begin bad++; $display("FAIL brake_release got=%b want=0000", out[3:0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) begin
        on = 2'($urandom); dir = 2'($urandom); duty_cycle = 8'($urandom);
        brake = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      end
      @(negedge clk);
      total++;
      if (got_vec !== exp_vec) begin bad++; $display("FAIL random c=%0d got=%h want=%h", c, got_vec, exp_vec); end
    end
  endtask

  task automatic test_reset_mid_drive();
    on = 2'b01; dir = 2'b01; brake = 2'b00; duty_cycle = 8'h0F;
    repeat (30) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (out !== 8'h00 || dead_active !== 2'b00) begin
      bad++; $display("FAIL reset_mid_drive out=%h dead=%b want out=00 dead=00", out, dead_active);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_dir_toggle();
    test_duty_change();
    test_brake();
    test_random();
    test_reset_mid_drive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
